pe_stream_fifo: RTL and testbench
=================================

# pe_stream_fifo

- Parametrised ready/valid data FIFO for the IO boundary of a PE.
- Decouples the PE datapath from the cluster network: configurable width and depth, true downstream backpressure, optional zero-latency bypass when empty, occupancy/almost-full status, and synchronous flush.
- Sits on every PE data input/output channel (ifmap, weight, psum) and replaces the fixed 4-deep, always-ready buffer.

## Interface
Parameters:
- DATA_WIDTH, 16, payload width in bits (≥1)
- DEPTH, 4, number of storage entries; power of two, ≥2
- BYPASS, 1, 1 = fall-through when empty (0-cycle latency); 0 = registered (1-cycle latency)
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)

Ports (CW = clog2(DEPTH)+1):
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of contents, same effect as reset on state
- in_valid  in  1  upstream word available
- in_ready  out  1  FIFO can accept; = ~full & ~reset & ~flush
- in_data  in  DATA_WIDTH  upstream word
- out_valid  out  1  word available to downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  head word
- count  out  CW  stored entries, 0..DEPTH
- almost_full  out  1  count ≥ AF_THRESH

## Operation
- Signals: push = in_valid & in_ready; pop = out_valid & out_ready; empty = (count==0); full = (count==DEPTH).
- Read and write pointers are clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is an explicit register; pointer equality is never used to infer full/empty.
- Non-empty: out_valid=1; out_data=mem[rd_ptr]; pop advances rd_ptr.
- Empty, BYPASS=1: out_valid=in_valid & ~flush; out_data=in_data. If out_ready, the word passes through without being written, and pointers and count are unchanged. Otherwise it is written and count becomes 1.
- Empty, BYPASS=0: out_valid=0; out_data=0. Push writes mem[wr_ptr].
- Count update: push & ~pop → count+1; pop & ~push → count−1; both (non-empty) → unchanged, with write and read the same cycle; bypass pass-through → unchanged.
- Full: in_ready=0 even when out_ready=1 that cycle. There is no combinational out_ready→in_ready path; in_ready rises the cycle after the pop.
- Flush: while flush is high, in_ready=0, out_valid=0, and no push or pop occurs. Next cycle pointers=0 and count=0. Storage contents are not cleared.
- Reset: pointers, count and almost_full return to 0; storage is not reset. While reset is high, in_ready=0 and out_valid=0. out_data=0 for BYPASS=0 and in_data for BYPASS=1.
- in_data is ignored when push=0. Upstream must hold in_valid and in_data until accepted; the FIFO does not check this.

## Timing
- Throughput: one push and one pop per cycle, sustained.
- Latency in→out: 0 cycles (BYPASS=1, empty); 1 cycle otherwise.
- in_ready, count and almost_full depend only on registered state plus reset and flush.
- out_valid and out_data are combinational from in_valid and in_data only in the BYPASS=1 empty case.
- Flush takes priority over push and pop. Reset takes priority over flush.
- Mid-operation reset or flush discards all stored words. The first push after deassertion is accepted in the same cycle in which in_ready is observed high.

## Structure
- Shared package pe_fifo_pkg holds:
  - a clog2 helper function;
  - a constant for the default PE data widths (ifmap, weight, psum), so channels instantiate consistently.
- One sub-module, pe_fifo_ram:
  - DEPTH×DATA_WIDTH, one synchronous write port, one asynchronous read port, no reset;
  - isolated so it can be swapped for a vendor FIFO/LUTRAM IP on FPGA.
- Pointer, count and bypass control stay in pe_stream_fifo.

## Test plan
- Fill/drain: DEPTH=4, BYPASS=0, out_ready=0.
  - Push 0x11,0x22,0x33,0x44 → count 1..4, almost_full at count 3, in_ready=0 at 4.
  - Then out_ready=1 → out_data 0x11,0x22,0x33,0x44 on consecutive cycles, count falls to 0.
- Bypass: BYPASS=1, empty, in_valid=1, in_data=0xAB, out_ready=1 → out_valid=1 and out_data=0xAB in the same cycle; count stays 0.
  - Repeat with out_ready=0 → count=1; next cycle out_data=0xAB from storage.
- Full with pop: full FIFO, in_valid=1, out_ready=1 → pop occurs, no push that cycle, count=3; in_ready=1 the next cycle.
- Wrap-around: 10 random push/pop cycles at 100% throughput, DEPTH=4 → output sequence equals input sequence; pointers wrap past 3 with no loss or duplication.
- Flush: 3 entries stored, flush=1 one cycle with in_valid=1 → word not accepted; next cycle count=0, out_valid=0 (BYPASS=0).
- Reset mid-stream: assert reset with count=2 → in_ready=0 and out_valid=0 during reset; count=0 after; a new push of 0x5A emerges first.

Source files
------------

// File: rtl/pe_fifo_pkg.sv
// Shared definitions for PE boundary FIFOs: a constant-foldable clog2 and
// the default data widths of each PE channel so every instance agrees.
package pe_fifo_pkg;

  localparam int unsigned IFMAP_WIDTH  = 16;
  localparam int unsigned WEIGHT_WIDTH = 16;
  localparam int unsigned PSUM_WIDTH   = 32;

  // Ceiling log2; usable in parameter and port-width expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
// Kept separate so an FPGA build can drop in vendor LUTRAM/FIFO IP.
module pe_fifo_ram
  import pe_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IFMAP_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                      clock,
  input  logic                      write_en,
  input  logic [clog2(DEPTH)-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic [clog2(DEPTH)-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]     read_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/pe_stream_fifo.sv
// Ready/valid FIFO for a PE data channel with explicit occupancy counter,
// optional fall-through when empty, almost-full status and synchronous flush.
module pe_stream_fifo
  import pe_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IFMAP_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned AF_THRESH  = DEPTH - 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    almost_full
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  pass_through;
  logic                  write_en;
  logic                  read_adv;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Acceptance depends only on registered occupancy, never on out_ready.
  assign in_ready = !full && !reset && !flush;

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    if (!empty) begin
      out_valid = !reset && !flush;
      out_data  = rd_data;
    end else if (BYPASS != 0) begin
      out_valid = in_valid && !reset && !flush;
      out_data  = in_data;
    end
    if (reset) begin
      out_data = (BYPASS != 0) ? in_data : '0;
    end
  end

  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  // An empty bypass FIFO hands the word straight through without storing it.
  assign pass_through = (BYPASS != 0) && empty && push && pop;
  assign write_en     = push && !pass_through;
  assign read_adv     = pop && !empty;

  always_comb begin
    count_next = count;
    if (write_en && !read_adv) begin
      count_next = count + CW'(1);
    end else if (read_adv && !write_en) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (read_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count_next;
      almost_full <= (count_next >= CW'(AF_THRESH));
    end
  end

  pe_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clock      (clock),
    .write_en   (write_en),
    .write_addr (wr_ptr),
    .write_data (in_data),
    .read_addr  (rd_ptr),
    .read_data  (rd_data)
  );

endmodule

// File: tb/tb_pe_stream_fifo.sv
// Bench for pe_stream_fifo: a registered (BYPASS=0) and a fall-through
// (BYPASS=1) instance, directed scenarios plus random traffic against queue models.
module tb_pe_stream_fifo;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, almost_full0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, almost_full1;
  logic [15:0] in_data0, out_data0, in_data1, out_data1;
  logic [2:0]  count0, count1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  always #5 clock = ~clock;

  pe_stream_fifo #(.DATA_WIDTH(16), .DEPTH(4), .BYPASS(0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .count(count0), .almost_full(almost_full0)
  );

  pe_stream_fifo #(.DATA_WIDTH(16), .DEPTH(4), .BYPASS(1)) dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1), .almost_full(almost_full1)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid0 = 1'b1; in_data0 = 16'h0012;
    in_valid1 = 1'b1; in_data1 = 16'h0077;
    tick();
    #1;
    n_checks++; if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin n_fail++;
      $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready0, in_ready1); end
    n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b/%b want 0/0", out_valid0, out_valid1); end
    n_checks++; if (out_data0 !== 16'h0000) begin n_fail++;
      $display("FAIL reset_out_data0: got %h want 0000", out_data0); end
    n_checks++; if (out_data1 !== 16'h0077) begin n_fail++;
      $display("FAIL reset_out_data1: got %h want 0077", out_data1); end
    n_checks++; if (count0 !== 3'd0 || count1 !== 3'd0 || almost_full0 !== 1'b0 || almost_full1 !== 1'b0) begin n_fail++;
      $display("FAIL reset_state: got count %0d/%0d af %b/%b want 0/0 0/0", count0, count1, almost_full0, almost_full1); end
    reset = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    #1;
    n_checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_ready: got %b/%b want 1/1", in_ready0, in_ready1); end
  endtask

  task automatic test_fill_drain;
    logic [15:0] vals [4];
    vals[0] = 16'h11; vals[1] = 16'h22; vals[2] = 16'h33; vals[3] = 16'h44;
    out_ready0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1; in_data0 = vals[i];
      #1;
      n_checks++; if (in_ready0 !== 1'b1) begin n_fail++;
        $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready0); end
      tick();
      n_checks++; if (count0 !== 3'(i + 1) || almost_full0 !== (i + 1 >= 3)) begin n_fail++;
        $display("FAIL fill_count[%0d]: got count %0d af %b want %0d %b", i, count0, almost_full0, i + 1, (i + 1 >= 3)); end
    end
    in_valid0 = 1'b0;
    #1;
    n_checks++; if (in_ready0 !== 1'b0) begin n_fail++;
      $display("FAIL full_ready: got %b want 0", in_ready0); end
    out_ready0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (out_valid0 !== 1'b1 || out_data0 !== vals[i]) begin n_fail++;
        $display("FAIL drain_data[%0d]: got %b %h want 1 %h", i, out_valid0, out_data0, vals[i]); end
      tick();
      n_checks++; if (count0 !== 3'(3 - i) || almost_full0 !== (3 - i >= 3)) begin n_fail++;
        $display("FAIL drain_count[%0d]: got count %0d af %b want %0d %b", i, count0, almost_full0, 3 - i, (3 - i >= 3)); end
    end
    #1;
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++;
      $display("FAIL drained_valid: got %b want 0", out_valid0); end
    out_ready0 = 1'b0;
  endtask

  task automatic test_full_pop;
    logic [15:0] exp [3];
    out_ready0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1; in_data0 = 16'(16'hC1 + i);
      tick();
    end
    in_data0 = 16'h0099; out_ready0 = 1'b1;
    #1;
    n_checks++; if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin n_fail++;
      $display("FAIL full_pop_ready: got in_ready %b out_valid %b want 0 1", in_ready0, out_valid0); end
    tick();
    n_checks++; if (count0 !== 3'd3 || in_ready0 !== 1'b1) begin n_fail++;
      $display("FAIL full_pop_after: got count %0d in_ready %b want 3 1", count0, in_ready0); end
    tick();
    in_valid0 = 1'b0;
    n_checks++; if (count0 !== 3'd3) begin n_fail++;
      $display("FAIL push_pop_count: got %0d want 3", count0); end
    exp[0] = 16'hC3; exp[1] = 16'hC4; exp[2] = 16'h0099;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (out_valid0 !== 1'b1 || out_data0 !== exp[i]) begin n_fail++;
        $display("FAIL full_pop_drain[%0d]: got %b %h want 1 %h", i, out_valid0, out_data0, exp[i]); end
      tick();
    end
    n_checks++; if (count0 !== 3'd0) begin n_fail++;
      $display("FAIL full_pop_empty: got %0d want 0", count0); end
    out_ready0 = 1'b0;
  endtask

  task automatic test_bypass;
    in_valid1 = 1'b1; in_data1 = 16'h00AB; out_ready1 = 1'b1;
    #1;
    n_checks++; if (out_valid1 !== 1'b1 || out_data1 !== 16'h00AB || in_ready1 !== 1'b1) begin n_fail++;
      $display("FAIL bypass_pass: got v %b d %h r %b want 1 00ab 1", out_valid1, out_data1, in_ready1); end
    tick();
    n_checks++; if (count1 !== 3'd0) begin n_fail++;
      $display("FAIL bypass_count: got %0d want 0", count1); end
    out_ready1 = 1'b0;
    #1;
    n_checks++; if (out_valid1 !== 1'b1 || out_data1 !== 16'h00AB) begin n_fail++;
      $display("FAIL bypass_stall_view: got %b %h want 1 00ab", out_valid1, out_data1); end
    tick();
    in_valid1 = 1'b0; in_data1 = 16'h0000;
    #1;
    n_checks++; if (count1 !== 3'd1 || out_valid1 !== 1'b1 || out_data1 !== 16'h00AB) begin n_fail++;
      $display("FAIL bypass_stored: got count %0d v %b d %h want 1 1 00ab", count1, out_valid1, out_data1); end
    out_ready1 = 1'b1;
    tick();
    n_checks++; if (count1 !== 3'd0 || out_valid1 !== 1'b0) begin n_fail++;
      $display("FAIL bypass_drain: got count %0d v %b want 0 0", count1, out_valid1); end
    out_ready1 = 1'b0;
  endtask

  task automatic test_flush;
    out_ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid0 = 1'b1; in_data0 = 16'(16'hD1 + i);
      tick();
    end
    flush = 1'b1; in_data0 = 16'h00EE;
    #1;
    n_checks++; if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin n_fail++;
      $display("FAIL flush_during: got in_ready %b out_valid %b want 0 0", in_ready0, out_valid0); end
    tick();
    flush = 1'b0; in_valid0 = 1'b0;
    #1;
    n_checks++; if (count0 !== 3'd0 || out_valid0 !== 1'b0 || almost_full0 !== 1'b0) begin n_fail++;
      $display("FAIL flush_after: got count %0d v %b af %b want 0 0 0", count0, out_valid0, almost_full0); end
    in_valid0 = 1'b1; in_data0 = 16'h0031;
    tick();
    in_valid0 = 1'b0;
    #1;
    n_checks++; if (count0 !== 3'd1 || out_data0 !== 16'h0031) begin n_fail++;
      $display("FAIL flush_refill: got count %0d d %h want 1 0031", count0, out_data0); end
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 16'h00A1; tick();
    in_data0 = 16'h00A2; tick();
    in_valid0 = 1'b0; reset = 1'b1;
    #1;
    n_checks++; if (count0 !== 3'd2 || in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid_during: got count %0d r %b v %b want 2 0 0", count0, in_ready0, out_valid0); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (count0 !== 3'd0 || in_ready0 !== 1'b1) begin n_fail++;
      $display("FAIL reset_mid_after: got count %0d r %b want 0 1", count0, in_ready0); end
    in_valid0 = 1'b1; in_data0 = 16'h005A;
    tick();
    in_valid0 = 1'b0;
    #1;
    n_checks++; if (out_valid0 !== 1'b1 || out_data0 !== 16'h005A || count0 !== 3'd1) begin n_fail++;
      $display("FAIL reset_mid_first: got v %b d %h count %0d want 1 005a 1", out_valid0, out_data0, count0); end
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
  endtask

  // Both instances see independent random traffic; models are plain queues.
  task automatic test_random;
    bit push0, pop0, push1, pop1, empty1, exp_ov1;
    logic [15:0] exp_od1;
    q0.delete(); q1.delete();
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!in_valid0 || push0) begin
        in_valid0 = (cyc < 14) ? 1'b1 : ($urandom_range(3) != 0);
        in_data0  = 16'($urandom);
      end
      if (!in_valid1 || push1) begin
        in_valid1 = (cyc < 14) ? 1'b1 : ($urandom_range(3) != 0);
        in_data1  = 16'($urandom);
      end
      out_ready0 = (cyc < 14) ? 1'b1 : ($urandom_range(3) != 0);
      out_ready1 = (cyc < 14) ? 1'b1 : ($urandom_range(3) != 0);
      #1;
      n_checks++; if (in_ready0 !== (q0.size() < 4) || out_valid0 !== (q0.size() != 0) || count0 !== 3'(q0.size())) begin n_fail++;
        $display("FAIL rand0_status[%0d]: got r %b v %b c %0d want r %b v %b c %0d", cyc, in_ready0, out_valid0, count0, q0.size() < 4, q0.size() != 0, q0.size()); end
      if (q0.size() != 0) begin
        n_checks++; if (out_data0 !== q0[0]) begin n_fail++;
          $display("FAIL rand0_data[%0d]: got %h want %h", cyc, out_data0, q0[0]); end
      end
      empty1  = (q1.size() == 0);
      exp_ov1 = empty1 ? in_valid1 : 1'b1;
      exp_od1 = empty1 ? in_data1 : q1[0];
      n_checks++; if (in_ready1 !== (q1.size() < 4) || out_valid1 !== exp_ov1 || count1 !== 3'(q1.size())) begin n_fail++;
        $display("FAIL rand1_status[%0d]: got r %b v %b c %0d want r %b v %b c %0d", cyc, in_ready1, out_valid1, count1, q1.size() < 4, exp_ov1, q1.size()); end
      if (exp_ov1) begin
        n_checks++; if (out_data1 !== exp_od1) begin n_fail++;
          $display("FAIL rand1_data[%0d]: got %h want %h", cyc, out_data1, exp_od1); end
      end
      push0 = in_valid0 && (q0.size() < 4);
      pop0  = out_ready0 && (q0.size() != 0);
      push1 = in_valid1 && (q1.size() < 4);
      pop1  = out_ready1 && exp_ov1;
      if (pop0) void'(q0.pop_front());
      if (push0) q0.push_back(in_data0);
      if (!(empty1 && push1 && pop1)) begin
        if (pop1) void'(q1.pop_front());
        if (push1) q1.push_back(in_data1);
      end
      tick();
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready0 = 1'b0; out_ready1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    tick();
    test_reset();
    test_fill_drain();
    test_full_pop();
    test_bypass();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
